// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned PACK_DEF  = 4;
    localparam int unsigned KEEP_MAX  = 64;

    typedef enum logic [0:0] {
        ACCUM,
        FLUSH_WAIT
    } pack_state_e;

    // Low 'cnt' bits set; callers keep only the PACK lanes they need.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// One-entry valid/ready output register holding a packed beat with keep and last.
module fifo_out_slot #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DSIZE*PACK-1:0] load_data_i,
    input  logic [PACK-1:0]       load_keep_i,
    input  logic                  load_last_i,
    input  logic                  ready_i,
    output logic [DSIZE*PACK-1:0] data_o,
    output logic [PACK-1:0]       keep_o,
    output logic                  last_o,
    output logic                  valid_o,
    output logic                  slot_free_o
);

    logic [DSIZE*PACK-1:0] data_q, data_d;
    logic [PACK-1:0]       keep_q, keep_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = load_data_i;
            keep_d  = load_keep_i;
            last_d  = load_last_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign data_o      = data_q;
    assign keep_o      = keep_q;
    assign last_o      = last_q;
    assign valid_o     = valid_q;
    assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words, packs PACK of them per output beat; flush closes a partial beat.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned PACK  = PACK_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [DSIZE-1:0]      rdata,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic                  flush,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int unsigned CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned AL = (PACK > 1) ? PACK - 1 : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

    pack_state_e               state_q, state_d;
    logic [CW-1:0]             asm_cnt_q, asm_cnt_d;
    logic [AL-1:0][DSIZE-1:0]  asm_q, asm_d;

    logic                      slot_free;
    logic                      flush_pend;
    logic                      load;
    logic [PACK-1:0][DSIZE-1:0] load_data;
    logic [PACK-1:0]           load_keep;
    logic                      load_last;
    logic [KEEP_MAX-1:0]       part_mask;

    assign flush_pend = (state_q == FLUSH_WAIT);

    // Last lane may only be popped when the output slot can take the completed beat.
    assign rinc = rrst_n && !rempty && !(flush_pend && asm_cnt_q != '0) &&
                  (asm_cnt_q != LAST_LANE || slot_free);

    always_comb begin
        state_d   = state_q;
        asm_cnt_d = asm_cnt_q;
        asm_d     = asm_q;
        load      = 1'b0;
        load_data = '0;
        load_keep = '0;
        load_last = 1'b0;
        part_mask = keep_mask(32'(asm_cnt_q));
        unique case (state_q)
            ACCUM: begin
                if (rinc) begin
                    if (asm_cnt_q == LAST_LANE) begin
                        load = 1'b1;
                        for (int i = 0; i < int'(PACK) - 1; i++) load_data[i] = asm_q[i];
                        load_data[PACK-1] = rdata;
                        load_keep = '1;
                        load_last = flush;
                        asm_cnt_d = '0;
                    end else begin
                        asm_d[asm_cnt_q] = rdata;
                        asm_cnt_d        = asm_cnt_q + CW'(1);
                        if (flush) state_d = FLUSH_WAIT;
                    end
                end else if (flush && asm_cnt_q != '0) begin
                    state_d = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (slot_free) begin
                    load = 1'b1;
                    // Lanes past asm_cnt may hold stale words; present them as zero.
                    for (int i = 0; i < int'(PACK) - 1; i++) begin
                        if (i < int'(asm_cnt_q)) load_data[i] = asm_q[i];
                    end
                    load_keep = part_mask[PACK-1:0];
                    load_last = 1'b1;
                    asm_cnt_d = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= ACCUM;
            asm_cnt_q <= '0;
            asm_q     <= '0;
        end else begin
            state_q   <= state_d;
            asm_cnt_q <= asm_cnt_d;
            asm_q     <= asm_d;
        end
    end

    fifo_out_slot #(
        .DSIZE (DSIZE),
        .PACK  (PACK)
    ) u_slot (
        .clk_i       (rclk),
        .rst_ni      (rrst_n),
        .load_i      (load),
        .load_data_i (load_data),
        .load_keep_i (load_keep),
        .load_last_i (load_last),
        .ready_i     (m_ready),
        .data_o      (m_data),
        .keep_o      (m_keep),
        .last_o      (m_last),
        .valid_o     (m_valid),
        .slot_free_o (slot_free)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed self-checking bench for fifo_rd_packer with DSIZE=8, PACK=4.
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    logic [7:0]  mem [64];
    int          wr_ptr;
    int          rd_ptr;
    int          cyc;
    int          n_tests;
    int          n_fail;

    logic [31:0] bd [$];
    logic [3:0]  bk [$];
    logic        bl [$];
    int          bc [$];
    int          pop_cyc [$];

    fifo_rd_packer #(
        .DSIZE (8),
        .PACK  (4)
    ) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[5:0]];

    initial rd_ptr = 0;
    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 1;

    initial cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    always @(negedge rclk) begin
        if (rinc) pop_cyc.push_back(cyc);
        if (m_valid && m_ready) begin
            bd.push_back(m_data);
            bk.push_back(m_keep);
            bl.push_back(m_last);
            bc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (bd.size() < n && k < budget) begin
            @(negedge rclk);
            k++;
        end
        check(tag, 32'(bd.size()), 32'(n));
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        if (idx < bd.size()) begin
            check({tag, "_data"}, bd[idx], d);
            check({tag, "_keep"}, 32'(bk[idx]), 32'(k));
            check({tag, "_last"}, 32'(bl[idx]), 32'(l));
        end else begin
            check({tag, "_present"}, 32'(bd.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int b0;
        int p0;
        n_tests = 0;
        n_fail  = 0;
        wr_ptr  = 0;
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;

        // Reset state, with a word already waiting in the FIFO
        push(8'h11);
        repeat (3) @(negedge rclk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'h0);
        check("rst_keep", 32'(m_keep), 32'h0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_rinc", 32'(rinc), 32'd0);

        // 1: single full beat, latency one cycle after last pop
        b0 = bd.size();
        p0 = pop_cyc.size();
        step();
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        push(8'h22);
        push(8'h33);
        push(8'h44);
        wait_beats(b0 + 1, 20, "t1_beats");
        check_beat("t1", b0, 32'h44332211, 4'hf, 1'b0);
        if (pop_cyc.size() >= p0 + 4 && bc.size() > b0)
            check("t1_latency", 32'(bc[b0] - pop_cyc[p0+3]), 32'd1);
        else
            check("t1_pops", 32'(pop_cyc.size()), 32'(p0 + 4));

        // 2: back-pressure with 8 words
        step();
        m_ready = 1'b0;
        b0 = bd.size();
        p0 = pop_cyc.size();
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (12) @(negedge rclk);
        check("t2_stall_pops", 32'(pop_cyc.size() - p0), 32'd7);
        check("t2_stall_rinc", 32'(rinc), 32'd0);
        check("t2_held_valid", 32'(m_valid), 32'd1);
        check("t2_held_data", m_data, 32'h04030201);
        repeat (3) @(negedge rclk);
        check("t2_stable_data", m_data, 32'h04030201);
        check("t2_stable_keep", 32'(m_keep), 32'hf);
        step();
        m_ready = 1'b1;
        wait_beats(b0 + 2, 20, "t2_beats");
        check_beat("t2a", b0, 32'h04030201, 4'hf, 1'b0);
        check_beat("t2b", b0 + 1, 32'h08070605, 4'hf, 1'b0);
        repeat (4) @(negedge rclk);
        check("t2_no_dup", 32'(bd.size() - b0), 32'd2);
        check("t2_all_popped", 32'(pop_cyc.size() - p0), 32'd8);

        // 3: partial beat via flush, no pops while it waits
        b0 = bd.size();
        step();
        push(8'hA1);
        push(8'hA2);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(8'h55);
        @(negedge rclk);
        check("t3_wait_rinc", 32'(rinc), 32'd0);
        wait_beats(b0 + 1, 10, "t3_beats");
        check_beat("t3", b0, 32'h0000A2A1, 4'b0011, 1'b1);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_beats(b0 + 2, 10, "t3b_beats");
        check_beat("t3b", b0 + 1, 32'h00000055, 4'b0001, 1'b1);

        // 4: idle flush is a no-op; flush on completing pop sets last
        repeat (2) step();
        b0 = bd.size();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) @(negedge rclk);
        check("t4_idle_flush", 32'(bd.size() - b0), 32'd0);
        step();
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        repeat (3) @(posedge rclk);
        #1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_beats(b0 + 1, 10, "t4_beats");
        check_beat("t4", b0, 32'h64636261, 4'hf, 1'b1);
        push(8'h71);
        push(8'h72);
        push(8'h73);
        push(8'h74);
        wait_beats(b0 + 2, 20, "t4b_beats");
        check_beat("t4b", b0 + 1, 32'h74737271, 4'hf, 1'b0);

        // 5: async reset mid-operation drops the held beat and partial assembly
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h81 + 8'(i));
        repeat (10) step();
        check("t5_pre_valid", 32'(m_valid), 32'd1);
        rrst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(m_valid), 32'd0);
        check("t5_rst_rinc", 32'(rinc), 32'd0);
        step();
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        b0 = bd.size();
        push(8'h91);
        push(8'h92);
        push(8'h93);
        push(8'h94);
        wait_beats(b0 + 1, 20, "t5_beats");
        check_beat("t5", b0, 32'h94939291, 4'hf, 1'b0);

        // 6: 16-word stream, one beat every 4 cycles, no bubbles
        repeat (2) step();
        b0 = bd.size();
        p0 = pop_cyc.size();
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
        wait_beats(b0 + 4, 40, "t6_beats");
        check_beat("t6a", b0, 32'hC3C2C1C0, 4'hf, 1'b0);
        check_beat("t6d", b0 + 3, 32'hCFCECDCC, 4'hf, 1'b0);
        if (pop_cyc.size() >= p0 + 16)
            check("t6_pop_span", 32'(pop_cyc[p0+15] - pop_cyc[p0]), 32'd15);
        else
            check("t6_pops", 32'(pop_cyc.size()), 32'(p0 + 16));
        for (int k = 1; k < 4; k++) begin
            if (bc.size() > b0 + k)
                check($sformatf("t6_gap%0d", k), 32'(bc[b0+k] - bc[b0+k-1]), 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
